// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encoding and default width.
package adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/FullAdderFunction.sv
// 1-bit full adder cell; the only arithmetic element in the serial adder.
module FullAdderFunction (
  input  logic inA,
  input  logic inB,
  input  logic carryIn,
  output logic carryOut,
  output logic out
);

  assign out      = inA ^ inB ^ carryIn;
  assign carryOut = (inA & inB) | (inA & carryIn) | (inB & carryIn);

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder: one full adder cell reused LSB-first over WIDTH cycles,
// with a start/ready handshake and a one-cycle done pulse.
module serial_add_sequencer
  import adder_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             carryIn,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reg_a, reg_b, sum_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_c;
  logic             accept, last;

  assign accept = start & ready;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  FullAdderFunction u_fa (
    .inA      (reg_a[0]),
    .inB      (reg_b[0]),
    .carryIn  (carry_q),
    .carryOut (fa_c),
    .out      (fa_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE:    begin ready = 1'b1; done = 1'b1; end
      default: ready = 1'b0;
    endcase
  end

  // New sum bits enter at the MSB so the LSB-first result lands aligned after WIDTH shifts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_a   <= '0;
      reg_b   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      reg_a   <= inA;
      reg_b   <= inB;
      sum_q   <= '0;
      carry_q <= carryIn;
      cnt     <= '0;
    end else if (state == RUN) begin
      reg_a   <= reg_a >> 1;
      reg_b   <= reg_b >> 1;
      sum_q   <= (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
      carry_q <= fa_c;
      cnt     <= cnt + 1'b1;
    end
  end

  assign sum      = sum_q;
  assign carryOut = carry_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed plus randomized checks of the serial adder at WIDTH=8 and WIDTH=1.
module tb_serial_add_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8, sum8;
  logic [0:0] a1, b1, sum1;
  logic       ci8, ci1, ready8, ready1, busy8, busy1, done8, done1, co8, co1;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt8 = 0, done_cnt1 = 0;
  int exp_done8 = 0, exp_done1 = 0;

  always #5 clk = ~clk;

  serial_add_sequencer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .inA(a8), .inB(b8), .carryIn(ci8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .carryOut(co8));

  serial_add_sequencer #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .inA(a1), .inB(b1), .carryIn(ci1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .carryOut(co1));

  always @(posedge clk) begin
    if (done8) done_cnt8 <= done_cnt8 + 1;
    if (done1) done_cnt1 <= done_cnt1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one addition; operands are scrambled right after the accepting edge.
  task automatic run_op(input bit w1, input logic [7:0] a, input logic [7:0] b, input logic ci,
                        output logic [8:0] res, output int lat, output int nbusy);
    lat = -1; nbusy = 0; res = 'x;
    @(negedge clk);
    if (w1) begin start1 = 1; a1 = a[0:0]; b1 = b[0:0]; ci1 = ci; exp_done1++; end
    else    begin start8 = 1; a8 = a; b8 = b; ci8 = ci; exp_done8++; end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start1 = 0; start8 = 0;
        a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
        a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
      end
      if (w1 ? busy1 : busy8) nbusy++;
      if (w1 ? done1 : done8) begin
        lat = k;
        res = w1 ? {7'd0, co1, sum1} : {co8, sum8};
        break;
      end
    end
  endtask

  initial begin
    logic [8:0] res, exp;
    logic [7:0] ra, rb;
    logic       rc;
    int         lat, nb, dbase;

    rst_n = 0; start8 = 0; start1 = 0;
    a8 = 0; b8 = 0; ci8 = 0; a1 = 0; b1 = 0; ci1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready8", ready8, 1); chk("rst_busy8", busy8, 0); chk("rst_done8", done8, 0);
    chk("rst_sum8", sum8, 0);     chk("rst_co8", co8, 0);
    chk("rst_ready1", ready1, 1); chk("rst_busy1", busy1, 0);
    rst_n = 1;

    // Basic: 5 + 3
    run_op(0, 8'h05, 8'h03, 0, res, lat, nb);
    chk("t1_lat", lat, 9); chk("t1_busy", nb, 8); chk("t1_res", res, 9'h008);

    run_op(0, 8'hFF, 8'h01, 0, res, lat, nb);
    chk("t2a_res", res, 9'h100);
    run_op(0, 8'hFF, 8'hFF, 1, res, lat, nb);
    chk("t2b_res", res, 9'h1FF);

    // Result held through IDLE
    repeat (3) @(negedge clk);
    chk("t5_hold_sum", sum8, 8'hFF); chk("t5_hold_co", co8, 1); chk("t5_idle_ready", ready8, 1);

    // start held high through RUN, then back-to-back accept in DONE
    dbase = done_cnt8;
    start8 = 1; a8 = 8'h10; b8 = 8'h20; ci8 = 0; exp_done8++;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done8) begin lat = k; break; end
    end
    chk("t3_lat", lat, 9); chk("t3_sum", sum8, 8'h30); chk("t3_co", co8, 0);
    chk("t3_one_done", done_cnt8 - dbase, 0);
    a8 = 8'h01; b8 = 8'h01; exp_done8++;
    @(negedge clk);
    start8 = 0;
    chk("t3_b2b_busy", busy8, 1);
    chk("t3_single_done", done_cnt8 - dbase, 1);
    lat = -1;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (done8) begin lat = k; break; end
    end
    chk("t3_b2b_lat", lat, 9); chk("t3_b2b_sum", sum8, 8'h02);

    // Reset in the middle of a run
    @(negedge clk);
    dbase = done_cnt8;
    start8 = 1; a8 = 8'hAA; b8 = 8'h55; ci8 = 0;
    repeat (4) begin @(negedge clk); start8 = 0; end
    chk("t4_mid_busy", busy8, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("t4_ready", ready8, 1); chk("t4_busy", busy8, 0); chk("t4_done", done8, 0);
    chk("t4_sum", sum8, 0);     chk("t4_co", co8, 0);
    repeat (12) @(negedge clk);
    chk("t4_no_done", done_cnt8 - dbase, 0);
    run_op(0, 8'h12, 8'h34, 1, res, lat, nb);
    chk("t4_after_res", res, 9'h047); chk("t4_after_lat", lat, 9);

    // Randomised sweep against plain arithmetic, both widths
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      run_op(0, ra, rb, rc, res, lat, nb);
      exp = 9'(ra) + 9'(rb) + 9'(rc);
      chk($sformatf("rnd8_%0d", i), {lat[7:0], res}, {8'd9, exp});
    end
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      run_op(1, ra, rb, rc, res, lat, nb);
      exp = 9'(ra[0]) + 9'(rb[0]) + 9'(rc);
      chk($sformatf("rnd1_%0d", i), {lat[7:0], nb[7:0], res}, {8'd2, 8'd1, exp});
    end

    repeat (3) @(negedge clk);
    chk("done_count8", done_cnt8, exp_done8);
    chk("done_count1", done_cnt1, exp_done1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
